step_generator: RTL and testbench

//  Memory-mapped step/dir pulse generator for one stepper axis; the top level instantiates one per gp step/dir pair.

---
 rtl/step_generator_pkg.sv | 46 ++++
 rtl/step_phase_timer.sv | 37 +++
 rtl/step_generator.sv | 237 +++++++++++++++++++++++
 tb/tb_step_generator.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_generator_pkg.sv
// ============================================================================
// Module      : step_generator_pkg
// Description : Shared definitions for the step/dir pulse generator: register
//               word offsets, CTRL bit positions and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package step_generator_pkg;

    // Register word offsets (addr_in = mem_addr[4:2])
    localparam logic [2:0] c_addr_ctrl     = 3'd0;
    localparam logic [2:0] c_addr_steps    = 3'd1;
    localparam logic [2:0] c_addr_period   = 3'd2;
    localparam logic [2:0] c_addr_remain   = 3'd3;
    localparam logic [2:0] c_addr_position = 3'd4;

    // CTRL write bits
    localparam int c_ctrl_start = 0;
    localparam int c_ctrl_dir   = 1;
    localparam int c_ctrl_abort = 2;

    // CTRL read bits
    localparam int c_stat_busy = 0;
    localparam int c_stat_dir  = 1;

    // Move sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    // Packs the CTRL read-back word
    function automatic logic [31:0] ctrl_status(input logic busy, input logic dir);
        logic [31:0] v;
        v              = '0;
        v[c_stat_busy] = busy;
        v[c_stat_dir]  = dir;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/step_phase_timer.sv
// ============================================================================
// Module      : step_phase_timer
// Description : Loadable down-counter. Loading N makes done assert in the
//               N-th cycle after the load, i.e. the phase lasts N cycles.
//               Stops at zero instead of wrapping. N must be >= 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_phase_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    // Load on request, otherwise count down and hold at zero
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign done = (r_count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/step_generator.sv
// ============================================================================
// Module      : step_generator
// Description : Memory-mapped step/dir pulse generator for one stepper axis.
//               Firmware loads STEPS/PERIOD, then writes CTRL.start; the block
//               emits DIR_SETUP+1 cycles of direction setup followed by STEPS
//               pulses of PULSE_WIDTH cycles, spaced by the clamped PERIOD.
//               Optional macro STEP_GEN_POSITION_EN adds a signed POSITION
//               register at offset 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_generator
    import step_generator_pkg::*;
#(
    parameter int PULSE_WIDTH = 50,
    parameter int DIR_SETUP   = 25,
    parameter int CNT_WIDTH   = 32
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic        enable,
    input  logic        write,
    input  logic [2:0]  addr_in,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ready,
    output logic        step_out,
    output logic        dir_out,
    output logic        busy_out
);

    localparam logic [CNT_WIDTH-1:0] c_pulse_len  = CNT_WIDTH'(PULSE_WIDTH);
    localparam logic [CNT_WIDTH-1:0] c_min_period = CNT_WIDTH'(PULSE_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] c_setup_len  = CNT_WIDTH'(DIR_SETUP + 1);

    state_t               r_state;
    logic                 r_ready;
    logic                 r_step;
    logic                 r_dir;
    logic                 r_busy;
    logic                 r_abort_pend;
    logic [CNT_WIDTH-1:0] r_steps;
    logic [CNT_WIDTH-1:0] r_period;
    logic [CNT_WIDTH-1:0] r_remain;

    logic                 w_commit;
    logic                 w_ctrl_wr;
    logic                 w_start_req;
    logic                 w_abort_req;
    logic                 w_go;
    logic                 w_to_high;
    logic                 w_high_done;
    logic                 w_to_low;
    logic                 w_timer_load;
    logic                 w_timer_done;
    logic [CNT_WIDTH-1:0] w_timer_value;
    logic [CNT_WIDTH-1:0] w_period_eff;
    logic [CNT_WIDTH-1:0] w_low_len;
    logic [CNT_WIDTH-1:0] w_remain_dec;
    logic [31:0]          w_rdata;

    // A write commits only on the edge where ready rises: once per access
    assign w_commit    = enable & write & ~r_ready;
    assign w_ctrl_wr   = w_commit & (addr_in == c_addr_ctrl);
    assign w_abort_req = w_ctrl_wr & data_in[c_ctrl_abort];
    assign w_start_req = w_ctrl_wr & data_in[c_ctrl_start] & ~data_in[c_ctrl_abort];

    assign w_go        = (r_state == ST_IDLE) & w_start_req & (r_steps != '0);
    assign w_to_high   = ~w_abort_req & w_timer_done &
                         ((r_state == ST_SETUP) | ((r_state == ST_LOW) & (r_remain != '0)));
    assign w_high_done = (r_state == ST_HIGH) & w_timer_done;
    assign w_to_low    = w_high_done & ~w_abort_req & ~r_abort_pend;

    // PERIOD is stored raw; the minimum legal spacing is applied on use
    assign w_period_eff = (r_period < c_min_period) ? c_min_period : r_period;
    assign w_low_len    = w_period_eff - c_pulse_len;
    assign w_remain_dec = (r_remain == '0) ? '0 : r_remain - CNT_WIDTH'(1);

    // Reload the phase timer on every phase entry with that phase's length
    always_comb begin
        w_timer_load  = 1'b1;
        w_timer_value = c_pulse_len;
        if (w_go) begin
            w_timer_value = c_setup_len;
        end else if (w_to_high) begin
            w_timer_value = c_pulse_len;
        end else if (w_to_low) begin
            w_timer_value = w_low_len;
        end else begin
            w_timer_load = 1'b0;
        end
    end

    step_phase_timer #(
        .WIDTH (CNT_WIDTH)
    ) u_phase_timer (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .load       (w_timer_load),
        .load_value (w_timer_value),
        .done       (w_timer_done)
    );

    // Registered bus handshake: ready follows enable by one cycle
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= enable;
        end
    end

    // STEPS and PERIOD configuration registers, writable at any time
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_steps  <= '0;
            r_period <= '0;
        end else if (w_commit) begin
            if (addr_in == c_addr_steps) begin
                r_steps <= data_in[CNT_WIDTH-1:0];
            end
            if (addr_in == c_addr_period) begin
                r_period <= data_in[CNT_WIDTH-1:0];
            end
        end
    end

    // Move sequencer; an abort seen in HIGH is deferred until the pulse ends
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state      <= ST_IDLE;
            r_step       <= 1'b0;
            r_dir        <= 1'b0;
            r_busy       <= 1'b0;
            r_remain     <= '0;
            r_abort_pend <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_state      <= ST_SETUP;
                        r_busy       <= 1'b1;
                        r_dir        <= data_in[c_ctrl_dir];
                        r_remain     <= r_steps;
                        r_abort_pend <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (w_abort_req) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_remain <= '0;
                    end else if (w_to_high) begin
                        r_state <= ST_HIGH;
                        r_step  <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (w_abort_req) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (w_high_done) begin
                        r_step <= 1'b0;
                        if (w_to_low) begin
                            r_state  <= ST_LOW;
                            r_remain <= w_remain_dec;
                        end else begin
                            r_state      <= ST_IDLE;
                            r_busy       <= 1'b0;
                            r_remain     <= '0;
                            r_abort_pend <= 1'b0;
                        end
                    end
                end
                ST_LOW: begin
                    if (w_abort_req) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_remain <= '0;
                    end else if (w_to_high) begin
                        r_state <= ST_HIGH;
                        r_step  <= 1'b1;
                    end else if (w_timer_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef STEP_GEN_POSITION_EN
    logic [31:0] r_position;

    // Position tracks step rising edges; a firmware write takes priority
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_position <= '0;
        end else if (w_commit && (addr_in == c_addr_position)) begin
            r_position <= data_in;
        end else if (w_to_high) begin
            r_position <= r_dir ? (r_position + 32'd1) : (r_position - 32'd1);
        end
    end
`endif

    // Read-back multiplexer
    always_comb begin
        w_rdata = '0;
        case (addr_in)
            c_addr_ctrl:     w_rdata = ctrl_status(r_busy, r_dir);
            c_addr_steps:    w_rdata = 32'(r_steps);
            c_addr_period:   w_rdata = 32'(r_period);
            c_addr_remain:   w_rdata = 32'(r_remain);
`ifdef STEP_GEN_POSITION_EN
            c_addr_position: w_rdata = r_position;
`else
            c_addr_position: w_rdata = '0;
`endif
            default:         w_rdata = '0;
        endcase
    end

    // The bus is shared, so only drive it while selected
    assign data_out = enable ? w_rdata : 'z;
    assign ready    = enable ? r_ready : 1'bz;
    assign step_out = r_step;
    assign dir_out  = r_dir;
    assign busy_out = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_step_generator.sv
// ============================================================================
// Module      : tb_step_generator
// Description : Self-checking bench for step_generator (PULSE_WIDTH=4,
//               DIR_SETUP=2). A pulse-schedule model predicts step/dir/busy
//               and register reads every cycle; directed scenarios add
//               literal timing checks, then a randomized bus sequence runs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_step_generator;

    localparam int PW = 4;
    localparam int DS = 2;

    logic        clk_in     = 1'b0;
    logic        reset_n_in = 1'b0;
    logic        enable     = 1'b0;
    logic        write      = 1'b0;
    logic [2:0]  addr_in    = 3'd0;
    logic [31:0] data_in    = 32'd0;
    wire  [31:0] data_out;
    wire         ready;
    logic        step_out;
    logic        dir_out;
    logic        busy_out;

    int errors = 0;
    int checks = 0;

    step_generator #(
        .PULSE_WIDTH (PW),
        .DIR_SETUP   (DS),
        .CNT_WIDTH   (32)
    ) dut (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .enable     (enable),
        .write      (write),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .data_out   (data_out),
        .ready      (ready),
        .step_out   (step_out),
        .dir_out    (dir_out),
        .busy_out   (busy_out)
    );

    always #20 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: absolute pulse schedule -----------
    int          cyc = 0;
    bit          m_ready, m_step, m_busy, m_dir, m_pend;
    logic [31:0] m_steps, m_period, m_remain, m_pos;
    longint      m_next_rise, m_fall, m_end;

    function automatic longint clampp(input logic [31:0] p);
        if (p < PW + 1) return longint'(PW + 1);
        return longint'(p);
    endfunction

    task automatic go_idle();
        m_busy = 0; m_step = 0; m_remain = 0; m_pend = 0;
        m_next_rise = -1; m_fall = -1; m_end = -1;
    endtask

    task automatic model_reset();
        go_idle();
        m_ready = 0; m_dir = 0; m_steps = 0; m_period = 0; m_pos = 0;
    endtask

    task automatic model_step();
        bit commit, ctrl, start, abort, was_high, rise;
        longint gap;
        cyc++;
        commit   = enable && write && !m_ready;
        m_ready  = enable;
        ctrl     = commit && (addr_in == 3'd0);
        start    = ctrl && data_in[0] && !data_in[2];
        abort    = ctrl && data_in[2];
        was_high = m_step;
        rise     = 0;
        if (m_busy) begin
            if (abort && !was_high) begin
                go_idle();
            end else begin
                if (abort) m_pend = 1;
                if (was_high && cyc == m_fall) begin
                    m_step = 0;
                    if (m_remain != 0) m_remain = m_remain - 1;
                    if (m_pend) go_idle();
                    else begin
                        gap = clampp(m_period) - PW;
                        if (m_remain == 0) begin m_end = cyc + gap; m_next_rise = -1; end
                        else begin m_next_rise = cyc + gap; m_end = -1; end
                    end
                end else if (!was_high && cyc == m_next_rise) begin
                    m_step = 1; m_fall = cyc + PW; rise = 1;
                end else if (!was_high && cyc == m_end) begin
                    go_idle();
                end
            end
        end else if (start && m_steps != 0) begin
            m_busy = 1; m_dir = data_in[1]; m_remain = m_steps; m_pend = 0;
            m_next_rise = cyc + DS + 1; m_end = -1; m_fall = -1;
        end
        if (rise) m_pos = m_dir ? m_pos + 1 : m_pos - 1;
        if (commit) begin
            case (addr_in)
                3'd1: m_steps  = data_in;
                3'd2: m_period = data_in;
                3'd4: m_pos    = data_in;
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [2:0] a);
        case (a)
            3'd0: return {30'd0, m_dir, m_busy};
            3'd1: return m_steps;
            3'd2: return m_period;
            3'd3: return m_remain;
`ifdef STEP_GEN_POSITION_EN
            3'd4: return m_pos;
`endif
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk_in or negedge reset_n_in);
            if (!reset_n_in) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare and pulse monitor ------------------
    int  rise_q[$];
    int  width_q[$];
    int  last_rise = 0;
    bit  prev_step = 0;

    initial forever begin
        @(negedge clk_in);
        chk("step_out", step_out, m_step);
        chk("busy_out", busy_out, m_busy);
        chk("dir_out",  dir_out,  m_dir);
        if (enable && reset_n_in) chk("ready", ready, m_ready);
        if (step_out && !prev_step) begin rise_q.push_back(cyc); last_rise = cyc; end
        if (!step_out && prev_step) width_q.push_back(cyc - last_rise);
        prev_step = step_out;
    end

    // ---------------- bus tasks --------------------------------------------
    int last_commit = 0;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        enable = 1; write = 1; addr_in = a; data_in = d;
        @(posedge clk_in); #1;
        last_commit = cyc;
        enable = 0; write = 0;
        @(posedge clk_in); #1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        enable = 1; write = 0; addr_in = a;
        @(posedge clk_in); #1;
        @(negedge clk_in);
        chk("read_ready", ready, 1'b1);
        d = data_out;
        chk($sformatf("read_addr%0d", a), data_out, exp_read(a));
        enable = 0;
        @(posedge clk_in); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (busy_out && k < limit) begin @(posedge clk_in); k++; end
        #1;
        chk("wait_idle_timeout", busy_out, 1'b0);
    endtask

    task automatic wait_rise(input int limit);
        int k = 0;
        while (!step_out && k < limit) begin @(negedge clk_in); k++; end
        chk("wait_rise_timeout", step_out, 1'b1);
        @(posedge clk_in); #1;
    endtask

    task automatic clear_log();
        rise_q.delete();
        width_q.delete();
    endtask

    initial begin
        #3500000;
        errors++;
        $display("FAIL watchdog: simulation ran too long");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- scenarios --------------------------------------------
    initial begin
        logic [31:0] rd;
        int op;

        // Reset state with reset asserted
        #5;
        enable = 1; addr_in = 3'd3;
        #1;
        chk("rst_remain_read", data_out, 32'd0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_step", step_out, 1'b0);
        chk("rst_busy", busy_out, 1'b0);
        chk("rst_dir", dir_out, 1'b0);
        enable = 0;
        repeat (3) @(posedge clk_in);
        #1 reset_n_in = 1;
        idle(1);

        // Basic move: 3 steps, period 10, dir 1
        bus_write(3'd1, 32'd3);
        bus_write(3'd2, 32'd10);
        clear_log();
        bus_write(3'd0, 32'b011);
        wait_idle(200);
        chk("t2_pulse_count", rise_q.size(), 3);
        if (rise_q.size() == 3 && width_q.size() == 3) begin
            chk("t2_first_rise", rise_q[0] - last_commit, DS + 1);
            chk("t2_spacing0", rise_q[1] - rise_q[0], 10);
            chk("t2_spacing1", rise_q[2] - rise_q[1], 10);
            for (int i = 0; i < 3; i++) chk("t2_width", width_q[i], PW);
        end
        bus_read(3'd3, rd);
        chk("t2_remain_zero", rd, 32'd0);
        bus_read(3'd0, rd);
        chk("t2_ctrl_read", rd, 32'b10);

        // Clamped period and zero-step start
        bus_write(3'd1, 32'd2);
        bus_write(3'd2, 32'd2);
        clear_log();
        bus_write(3'd0, 32'b001);
        wait_idle(200);
        chk("t3_pulse_count", rise_q.size(), 2);
        if (rise_q.size() == 2) chk("t3_clamped_spacing", rise_q[1] - rise_q[0], PW + 1);
        bus_write(3'd1, 32'd0);
        clear_log();
        bus_write(3'd0, 32'b001);
        idle(20);
        chk("t3_zero_steps_pulses", rise_q.size(), 0);
        chk("t3_zero_steps_busy", busy_out, 1'b0);

        // Abort two cycles into a pulse
        bus_write(3'd1, 32'd3);
        bus_write(3'd2, 32'd10);
        clear_log();
        bus_write(3'd0, 32'b001);
        wait_rise(50);
        bus_write(3'd0, 32'b100);
        wait_idle(100);
        chk("t4_pulse_count", rise_q.size(), 1);
        if (width_q.size() == 1) chk("t4_full_width", width_q[0], PW);
        bus_read(3'd3, rd);
        chk("t4_remain_zero", rd, 32'd0);

        // Start while busy ignored; PERIOD change applies from next LOW entry
        bus_write(3'd1, 32'd3);
        bus_write(3'd2, 32'd8);
        clear_log();
        bus_write(3'd0, 32'b001);
        bus_write(3'd1, 32'd5);
        bus_write(3'd0, 32'b011);
        idle(2);
        bus_write(3'd2, 32'd6);
        wait_idle(200);
        chk("t5_pulse_count", rise_q.size(), 3);
        if (rise_q.size() == 3) begin
            chk("t5_spacing_old", rise_q[1] - rise_q[0], 8);
            chk("t5_spacing_new", rise_q[2] - rise_q[1], 6);
        end
        chk("t5_dir_kept", dir_out, 1'b0);
        bus_read(3'd1, rd);
        chk("t5_steps_updated", rd, 32'd5);
        clear_log();
        bus_write(3'd0, 32'b101);
        idle(20);
        chk("t5_start_abort_pulses", rise_q.size(), 0);
        chk("t5_start_abort_busy", busy_out, 1'b0);

        // Position register / unused offsets
`ifdef STEP_GEN_POSITION_EN
        bus_write(3'd4, 32'd0);
        bus_write(3'd2, 32'd5);
        bus_write(3'd1, 32'd5);
        bus_write(3'd0, 32'b011);
        wait_idle(200);
        bus_write(3'd1, 32'd2);
        bus_write(3'd0, 32'b001);
        wait_idle(200);
        bus_read(3'd4, rd);
        chk("t6_position", rd, 32'd3);
        bus_write(3'd4, 32'hFFFF_FFFF);
        bus_read(3'd4, rd);
        chk("t6_position_load", rd, 32'hFFFF_FFFF);
`else
        bus_write(3'd4, 32'h1234);
        bus_read(3'd4, rd);
        chk("t6_offset4_zero", rd, 32'd0);
`endif
        bus_write(3'd5, 32'hDEAD);
        bus_read(3'd5, rd);
        chk("t6_offset5_zero", rd, 32'd0);
        bus_write(3'd2, 32'hFFFF_FFFF);
        bus_read(3'd2, rd);
        chk("t6_period_max", rd, 32'hFFFF_FFFF);

        // Mid-pulse asynchronous reset
        bus_write(3'd2, 32'd10);
        bus_write(3'd1, 32'd2);
        bus_write(3'd0, 32'b011);
        wait_rise(50);
        #5 reset_n_in = 0;
        #1;
        chk("async_rst_step", step_out, 1'b0);
        chk("async_rst_busy", busy_out, 1'b0);
        chk("async_rst_dir", dir_out, 1'b0);
        enable = 1; addr_in = 3'd3;
        #1;
        chk("async_rst_remain", data_out, 32'd0);
        enable = 0;
        @(posedge clk_in); #1 reset_n_in = 1;
        idle(1);

        // Randomized traffic against the model
        for (int n = 0; n < 250; n++) begin
            op = $urandom_range(0, 10);
            case (op)
                0, 1:    bus_write(3'd1, 32'($urandom_range(0, 4)));
                2, 3:    bus_write(3'd2, 32'($urandom_range(0, 12)));
                4, 5:    bus_write(3'd0, {29'd0, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), 1'b1});
                6:       bus_write(3'd0, 32'b100);
                7, 8:    bus_read(3'($urandom_range(0, 7)), rd);
                9:       bus_write(3'($urandom_range(3, 7)), $urandom);
                default: idle($urandom_range(1, 15));
            endcase
        end
        wait_idle(500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
